// File: rtl/pe_os_drain_pkg.sv
// Shared definitions for the output-stationary PE with result drain.
//   state_t          : PE controller states (ACC accumulating, DRAIN forwarding chain)
//   *_W_DEF          : default operand / accumulator widths
//   acc_max/acc_min  : signed extremes of a w-bit accumulator, as 64-bit values
// Optional feature macro used by this block: PE_OS_SATURATE_EN.
package pe_os_pkg;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int A_W_DEF   = 8;
    localparam int B_W_DEF   = 8;
    localparam int ACC_W_DEF = 24;

    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_os_drain_if.sv
// Bus bundle for one output-stationary PE.
//   slave  : the PE side (operands, control and drain chain in; forwarded
//            operands, drain output and status out)
//   master : the driver side (neighbouring PEs / array controller / bench)
interface pe_os_drain_if
    import pe_os_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic signed [A_W-1:0]   up,   down;
    logic                    up_valid, down_valid;
    logic signed [B_W-1:0]   left, right;
    logic                    left_valid, right_valid;
    logic                    clear, drain_start;
    logic signed [ACC_W-1:0] psum_in, psum_out, acc_out;
    logic                    psum_in_valid, psum_in_last;
    logic                    psum_out_valid, psum_out_last;
    logic                    draining, sat_flag;

    modport slave (
        input  up, up_valid, left, left_valid, clear, drain_start,
               psum_in, psum_in_valid, psum_in_last,
        output down, down_valid, right, right_valid,
               psum_out, psum_out_valid, psum_out_last,
               acc_out, draining, sat_flag
    );

    modport master (
        output up, up_valid, left, left_valid, clear, drain_start,
               psum_in, psum_in_valid, psum_in_last,
        input  down, down_valid, right, right_valid,
               psum_out, psum_out_valid, psum_out_last,
               acc_out, draining, sat_flag
    );
endinterface

// File: rtl/pe_mac_sat.sv
// Combinational multiply-accumulate step: sum = base + (fire ? a*b : 0).
//   a, b  : signed operands
//   fire  : include the product
//   base  : accumulator value to add onto (0 when starting a new tile)
//   sum   : next accumulator value
//   ovf   : signed overflow of this add (always 0 unless PE_OS_SATURATE_EN)
// With PE_OS_SATURATE_EN defined the sum clamps to the signed ACC_W range;
// otherwise it wraps in two's complement.
module pe_mac_sat
    import pe_os_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic                    fire,
    input  logic signed [ACC_W-1:0] base,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W-1:0]   raw;

    assign prod   = a * b;
    // Signed size cast sign-extends, and also covers ACC_W == A_W+B_W.
    assign addend = fire ? ACC_W'(prod) : '0;
    assign raw    = base + addend;

`ifdef PE_OS_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

    // Overflow only when both addends share a sign and the result flips it.
    assign ovf = (base[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
    assign sum = ovf ? (base[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign ovf = 1'b0;
    assign sum = raw;
`endif
endmodule

// File: rtl/pe_os_drain.sv
// Output-stationary systolic PE with a vertical result-drain chain.
//   clk, reset_b : clock, asynchronous active-low reset
//   bus (slave)  : up/left operands forwarded down/right with 1-cycle latency;
//                  MAC fires when both operands are valid; drain_start emits
//                  the finished tile result then forwards psum_in until the
//                  upstream burst's last word; clear zeroes and aborts.
// Optional feature: PE_OS_SATURATE_EN (saturating accumulate, sticky sat_flag).
module pe_os_drain
    import pe_os_pkg::*;
#(
    parameter int A_W        = A_W_DEF,
    parameter int B_W        = B_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter bit CHAIN_HEAD = 1'b0
) (
    input  logic          clk,
    input  logic          reset_b,
    pe_os_drain_if.slave  bus
);
    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, base, mac_sum;
    logic                    fire, mac_ovf, emit, sat_q;

    assign fire = bus.up_valid && bus.left_valid;
    // Emitting the finished tile: the same-cycle product seeds the next tile.
    assign emit = (state == ST_ACC) && bus.drain_start && !bus.clear;
    assign base = emit ? '0 : acc;

    pe_mac_sat #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) u_mac (
        .a    (bus.up),
        .b    (bus.left),
        .fire (fire),
        .base (base),
        .sum  (mac_sum),
        .ovf  (mac_ovf)
    );

    always_comb begin
        state_nxt = state;
        if (bus.clear)
            state_nxt = ST_ACC;
        else if (state == ST_ACC) begin
            if (bus.drain_start && !CHAIN_HEAD)
                state_nxt = ST_DRAIN;
        end else if (bus.psum_in_valid && bus.psum_in_last)
            state_nxt = ST_ACC;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    // Operand forwarding ignores state and clear.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bus.down        <= '0;
            bus.down_valid  <= 1'b0;
            bus.right       <= '0;
            bus.right_valid <= 1'b0;
        end else begin
            bus.down        <= bus.up;
            bus.down_valid  <= bus.up_valid;
            bus.right       <= bus.left;
            bus.right_valid <= bus.left_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc                <= '0;
            sat_q              <= 1'b0;
            bus.psum_out       <= '0;
            bus.psum_out_valid <= 1'b0;
            bus.psum_out_last  <= 1'b0;
        end else if (bus.clear) begin
            acc                <= '0;
            sat_q              <= 1'b0;
            bus.psum_out_valid <= 1'b0;
            bus.psum_out_last  <= 1'b0;
        end else begin
            acc <= mac_sum;
            if (mac_ovf)
                sat_q <= 1'b1;
            if (state == ST_DRAIN) begin
                bus.psum_out       <= bus.psum_in;
                bus.psum_out_valid <= bus.psum_in_valid;
                bus.psum_out_last  <= bus.psum_in_last;
            end else if (bus.drain_start) begin
                bus.psum_out       <= acc;
                bus.psum_out_valid <= 1'b1;
                bus.psum_out_last  <= CHAIN_HEAD;
            end else begin
                bus.psum_out_valid <= 1'b0;
                bus.psum_out_last  <= 1'b0;
            end
        end
    end

    assign bus.acc_out  = acc;
    assign bus.draining = (state == ST_DRAIN);
    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_pe_os_drain.sv
module tb_pe_os_drain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_os_drain_if #(.A_W(8), .B_W(8), .ACC_W(24)) bm();
    pe_os_drain_if #(.A_W(8), .B_W(8), .ACC_W(24)) bh();
    pe_os_drain_if #(.A_W(8), .B_W(8), .ACC_W(16)) bs();

    pe_os_drain #(.A_W(8), .B_W(8), .ACC_W(24), .CHAIN_HEAD(1'b0)) u_main (
        .clk(clk), .reset_b(rst_n), .bus(bm.slave));
    pe_os_drain #(.A_W(8), .B_W(8), .ACC_W(24), .CHAIN_HEAD(1'b1)) u_head (
        .clk(clk), .reset_b(rst_n), .bus(bh.slave));
    pe_os_drain #(.A_W(8), .B_W(8), .ACC_W(16), .CHAIN_HEAD(1'b0)) u_sat (
        .clk(clk), .reset_b(rst_n), .bus(bs.slave));

    typedef struct packed {
        logic signed [23:0] d;
        logic               l;
    } word_t;

    word_t qm[$];
    word_t qh[$];
    int n_chk  = 0;
    int n_pass = 0;

`ifdef PE_OS_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic word_t mk(input int d, input bit l);
        word_t w;
        w.d = 24'(d);
        w.l = l;
        return w;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mset(input int a, input bit av, input int b, input bit bv);
        bm.up = 8'(a); bm.up_valid = av; bm.left = 8'(b); bm.left_valid = bv;
    endtask

    // Drain-chain monitors: every valid word must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && bm.psum_out_valid) begin
            word_t w;
            if (qm.size() == 0) check("main_spurious_valid", bm.psum_out_valid, 0);
            else begin
                w = qm.pop_front();
                check("main_psum", bm.psum_out, w.d);
                check("main_last", bm.psum_out_last, w.l);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bh.psum_out_valid) begin
            word_t w;
            if (qh.size() == 0) check("head_spurious_valid", bh.psum_out_valid, 0);
            else begin
                w = qh.pop_front();
                check("head_psum", bh.psum_out, w.d);
                check("head_last", bh.psum_out_last, w.l);
            end
        end
    end

    initial begin
        mset(0, 0, 0, 0);
        bm.clear = 0; bm.drain_start = 0; bm.psum_in = '0; bm.psum_in_valid = 0; bm.psum_in_last = 0;
        bh.up = '0; bh.up_valid = 0; bh.left = '0; bh.left_valid = 0;
        bh.clear = 0; bh.drain_start = 0; bh.psum_in = '0; bh.psum_in_valid = 0; bh.psum_in_last = 0;
        bs.up = '0; bs.up_valid = 0; bs.left = '0; bs.left_valid = 0;
        bs.clear = 0; bs.drain_start = 0; bs.psum_in = '0; bs.psum_in_valid = 0; bs.psum_in_last = 0;

        // reset state
        #12;
        check("rst_acc", bm.acc_out, 0);
        check("rst_psum_valid", bm.psum_out_valid, 0);
        check("rst_draining", bm.draining, 0);
        check("rst_down_valid", bm.down_valid, 0);
        check("rst_sat", bm.sat_flag, 0);
        rst_n = 1;
        step();

        // accumulate 4x (3 * -5), operands echoed one cycle later
        mset(3, 1, -5, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fwd_down", bm.down, 3);
            check("fwd_down_valid", bm.down_valid, 1);
            check("fwd_right", bm.right, -5);
            check("fwd_right_valid", bm.right_valid, 1);
            check("acc_run", bm.acc_out, -15 * (i + 1));
        end
        mset(3, 1, 0, 0);
        step();
        check("acc_idle", bm.acc_out, -60);
        check("fwd_right_valid_lo", bm.right_valid, 0);
        mset(0, 0, 0, 0);

        // drain with CHAIN_HEAD=0
        bm.clear = 1; step(); bm.clear = 0;
        check("clear_acc", bm.acc_out, 0);
        mset(10, 1, 10, 1); step();
        check("acc_100", bm.acc_out, 100);
        mset(2, 1, 7, 1); bm.drain_start = 1; qm.push_back(mk(100, 0));
        step();
        bm.drain_start = 0; mset(0, 0, 0, 0);
        check("drain_new_tile_acc", bm.acc_out, 14);
        check("drain_state", bm.draining, 1);
        // drain_start inside DRAIN must be ignored
        bm.psum_in = 55; bm.psum_in_valid = 1; bm.psum_in_last = 0; bm.drain_start = 1;
        qm.push_back(mk(55, 0));
        step();
        bm.drain_start = 0;
        check("drain_hold", bm.draining, 1);
        check("drain_acc_hold", bm.acc_out, 14);
        bm.psum_in = 66; bm.psum_in_last = 1; qm.push_back(mk(66, 1));
        step();
        bm.psum_in_valid = 0; bm.psum_in_last = 0;
        check("drain_done", bm.draining, 0);
        step(2);

        // clear beats drain_start and fire
        bm.clear = 1; step(); bm.clear = 0;
        mset(5, 1, 10, 1); step();
        check("acc_50", bm.acc_out, 50);
        mset(1, 1, 1, 1); bm.clear = 1; bm.drain_start = 1;
        step();
        bm.clear = 0; bm.drain_start = 0; mset(0, 0, 0, 0);
        check("prio_acc", bm.acc_out, 0);
        check("prio_no_emit", bm.psum_out_valid, 0);
        check("prio_state", bm.draining, 0);

        // clear mid-DRAIN aborts
        mset(4, 1, 4, 1); step(); mset(0, 0, 0, 0);
        bm.drain_start = 1; qm.push_back(mk(16, 0));
        step();
        bm.drain_start = 0;
        check("abort_enter", bm.draining, 1);
        bm.clear = 1; bm.psum_in = 77; bm.psum_in_valid = 1;
        step();
        bm.clear = 0; bm.psum_in_valid = 0;
        check("abort_valid", bm.psum_out_valid, 0);
        check("abort_state", bm.draining, 0);

        // head PE: single word with last, never draining
        bh.up = 3; bh.up_valid = 1; bh.left = 3; bh.left_valid = 1;
        step();
        bh.up_valid = 0; bh.left_valid = 0; bh.drain_start = 1;
        qh.push_back(mk(9, 1));
        step();
        bh.drain_start = 0;
        check("head_draining", bh.draining, 0);
        check("head_acc", bh.acc_out, 0);
        step();
        check("head_draining2", bh.draining, 0);

        // 16-bit accumulator overflow
        bs.up = 127; bs.up_valid = 1; bs.left = 127; bs.left_valid = 1;
        step();
        check("sat_acc1", bs.acc_out, 16129);
        step();
        check("sat_acc2", bs.acc_out, 32258);
        step();
        check("sat_acc3", bs.acc_out, SAT ? 32767 : -17149);
        check("sat_flag3", bs.sat_flag, SAT ? 1 : 0);
        step();
        check("sat_acc4", bs.acc_out, SAT ? 32767 : -1020);
        check("sat_flag4", bs.sat_flag, SAT ? 1 : 0);
        bs.up_valid = 0; bs.left_valid = 0; bs.clear = 1;
        step();
        bs.clear = 0;
        check("sat_clear_acc", bs.acc_out, 0);
        check("sat_clear_flag", bs.sat_flag, 0);

        // async reset mid-DRAIN, between clock edges
        bm.clear = 1; step(); bm.clear = 0;
        mset(2, 1, 3, 1); step();
        mset(1, 1, 4, 1); bm.drain_start = 1; qm.push_back(mk(6, 0));
        step();
        bm.drain_start = 0; mset(1, 1, 0, 0);
        check("ar_draining", bm.draining, 1);
        check("ar_acc", bm.acc_out, 4);
        @(negedge clk); #2;
        rst_n = 0; #1;
        check("ar_acc0", bm.acc_out, 0);
        check("ar_psum0", bm.psum_out, 0);
        check("ar_valid0", bm.psum_out_valid, 0);
        check("ar_draining0", bm.draining, 0);
        check("ar_down_valid0", bm.down_valid, 0);
        #1 rst_n = 1;
        mset(0, 0, 0, 0);
        step();
        check("ar_state_after", bm.draining, 0);
        check("ar_acc_after", bm.acc_out, 0);

        step(2);
        check("main_queue_empty", qm.size(), 0);
        check("head_queue_empty", qh.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
